// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the internal data-bus arbiter.
package bus_arbiter_pkg;

   localparam int NUM_SRC = 16;
   localparam int CODE_W  = 4;
   localparam int HOLD_W  = 8;
   localparam int TURN_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   // 4-to-16 bus-enable decode shared with the enable decoder.
   function automatic logic [NUM_SRC-1:0] dec4to16(input logic [CODE_W-1:0] code);
      logic [NUM_SRC-1:0] onehot;
      onehot       = '0;
      onehot[code] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin pick: lowest set request bit searching upward from last+1, wrapping.
module bus_arbiter_rr_pick
   import bus_arbiter_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [CODE_W-1:0]  last,
   output logic [CODE_W-1:0]  winner,
   output logic               any
);

   logic [CODE_W-1:0]    start;
   logic [CODE_W:0]      shift;
   logic [2*NUM_SRC-1:0] dbl;
   logic [NUM_SRC-1:0]   rot;
   logic [CODE_W-1:0]    pos;

   // Rotate so bit 0 is last+1, priority-encode the lowest bit, rotate back.
   always_comb begin
      start = last + 4'd1;
      shift = {1'b0, start};
      dbl   = {req, req};
      rot   = dbl[shift +: NUM_SRC];
      pos   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (rot[i]) pos = CODE_W'(i);
      end
      winner = start + pos;
      any    = |req;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared internal data bus, with hold
// timeout and a turnaround gap between owners.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; arbitrate among requesters at the next edge
//   GRANT | owner grant_code drives the bus until release or timeout
//   TURN  | bus turnaround, no owner, requests ignored
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD    = 64,
   parameter int TURN_CYCLES = 1
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [NUM_SRC-1:0]  req,
   output logic                grant_valid,
   output logic [CODE_W-1:0]   grant_code,
   output logic [NUM_SRC-1:0]  grant_onehot,
   output logic                timeout
);

   localparam logic              HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic              TURN_EN   = (TURN_CYCLES != 0);
   localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

   state_t              state;
   logic [CODE_W-1:0]   last;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [TURN_W-1:0]   turn_cnt;
   logic [CODE_W-1:0]   winner;
   logic                any;
   logic                owner_req;
   logic                release_now;

   bus_arbiter_rr_pick u_rr_pick (
      .req    (req),
      .last   (last),
      .winner (winner),
      .any    (any)
   );

   assign owner_req   = req[grant_code];
   // A release with the owner still requesting can only be the hold timeout.
   assign release_now = !owner_req || (HOLD_EN && (hold_cnt == HOLD_LAST));

   // Arbitration FSM; every output is registered here, one-hot decoded from the
   // code being loaded so it never disagrees with grant_valid.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         grant_valid  <= 1'b0;
         grant_code   <= '0;
         grant_onehot <= '0;
         timeout      <= 1'b0;
         last         <= 4'd15;
         hold_cnt     <= '0;
         turn_cnt     <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  state        <= GRANT;
                  grant_valid  <= 1'b1;
                  grant_code   <= winner;
                  grant_onehot <= dec4to16(winner);
                  last         <= winner;
                  hold_cnt     <= '0;
               end
            end
            GRANT: begin
               if (hold_cnt != '1) hold_cnt <= hold_cnt + 8'd1;
               if (release_now) begin
                  grant_valid  <= 1'b0;
                  grant_onehot <= '0;
                  timeout      <= owner_req;
                  turn_cnt     <= TURN_LOAD;
                  state        <= TURN_EN ? TURN : IDLE;
               end
            end
            TURN: begin
               if (turn_cnt == '0) state    <= IDLE;
               else                turn_cnt <= turn_cnt - 2'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
